// File: rtl/mano_mem_ctrl_if.sv
// Load/read bus between mano_mem_ctrl and the program source / MAR-MBR side.
// master drives load words and read strobes; slave is the memory stage.
interface mano_mem_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              ld_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;
  logic              run;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ack;
  logic              busy;
  logic              err_oob;
  logic              err_ovf;
  logic [DATA_W-1:0] checksum;

  modport master (
    output ld_start, ld_valid, ld_data, ld_done, rd_req, rd_addr,
    input  ld_ready, run, rd_data, rd_ack, busy, err_oob, err_ovf, checksum
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_done, rd_req, rd_addr,
    output ld_ready, run, rd_data, rd_ack, busy, err_oob, err_ovf, checksum
  );
endinterface

// File: rtl/mano_mem_ctrl.sv
// Main-memory stage: LOAD fills the word array, RUN serves fixed-latency reads.
// Optional MEM_CHECKSUM_EN builds a running sum of the words of the current load.
module mano_mem_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 9,
  parameter int RD_LAT = 1
) (
  input logic           clock,
  input logic           reset,
  mano_mem_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic              addr_ok_q;
  logic              req_q, busy_q, ack_q, oob_q, ovf_q;
  logic [DATA_W-1:0] data_q;

  logic ptr_full, ld_hs, enter_load, rd_edge, abort, accept, drop, finish, addr_ok;

  always_comb begin
    ptr_full   = (ptr == PTR_W'(DEPTH));
    ld_hs      = (state == S_LOAD) && !ptr_full && bus.ld_valid;
    enter_load = ((state == S_IDLE) || (state == S_RUN)) && bus.ld_start;
    rd_edge    = bus.rd_req && !req_q;
    abort      = (state == S_RUN) && bus.ld_start;
    // An edge landing on the rd_ack cycle is treated as colliding with the read.
    accept     = (state == S_RUN) && !abort && rd_edge && !busy_q && !ack_q;
    drop       = (state == S_RUN) && !abort && rd_edge && (busy_q || ack_q);
    finish     = (state == S_RUN) && !abort && busy_q && (cnt == CNT_W'(1));
    addr_ok    = ({1'b0, bus.rd_addr} < (ADDR_W + 1)'(DEPTH));
  end

  always_comb begin
    state_nxt    = state;
    bus.ld_ready = 1'b0;
    bus.run      = 1'b0;
    unique case (state)
      S_IDLE: if (bus.ld_start) state_nxt = S_LOAD;
      S_LOAD: begin
        bus.ld_ready = !ptr_full;
        if (bus.ld_done) state_nxt = S_RUN;
      end
      S_RUN: begin
        bus.run = 1'b1;
        if (bus.ld_start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) mem[IDX_W'(i)] <= '0;
      ptr       <= '0;
      cnt       <= '0;
      idx_q     <= '0;
      addr_ok_q <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      oob_q     <= 1'b0;
      ovf_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state <= state_nxt;
      req_q <= bus.rd_req;
      ack_q <= finish;
      if (ld_hs) begin
        mem[ptr[IDX_W-1:0]] <= bus.ld_data;
        ptr <= ptr + 1'b1;
      end
      if (enter_load) ptr <= '0;
      if ((state == S_LOAD) && ptr_full && bus.ld_valid) oob_q <= 1'b1;
      if (abort) begin
        busy_q <= 1'b0;
        cnt    <= '0;
      end else if (accept) begin
        busy_q    <= 1'b1;
        cnt       <= CNT_W'(RD_LAT);
        idx_q     <= bus.rd_addr[IDX_W-1:0];
        addr_ok_q <= addr_ok;
        if (!addr_ok) oob_q <= 1'b1;
      end else if (busy_q) begin
        cnt <= cnt - 1'b1;
        if (finish) begin
          busy_q <= 1'b0;
          data_q <= addr_ok_q ? mem[idx_q] : '0;
        end
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign bus.rd_data = data_q;
  assign bus.rd_ack  = ack_q;
  assign bus.busy    = busy_q;
  assign bus.err_oob = oob_q;
  assign bus.err_ovf = ovf_q;

`ifdef MEM_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clock) begin
    if (reset)           sum_q <= '0;
    else if (enter_load) sum_q <= '0;
    else if (ld_hs)      sum_q <= sum_q + bus.ld_data;
  end

  assign bus.checksum = sum_q;
`else
  assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_mano_mem_ctrl.sv
// Bench for mano_mem_ctrl: directed scenarios with literal checks, then random
// traffic, all compared each cycle against a behavioural memory model.
module tb_mano_mem_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 9;
  localparam int RD_LAT = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mano_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mano_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory image, load pointer, and one pending read with its due cycle.
  typedef enum {M_IDLE, M_LOAD, M_RUN} mode_t;
  mode_t      m_mode;
  logic [7:0] m_mem [DEPTH];
  int         m_ptr, m_addr, m_due, cyc;
  logic [7:0] m_sum, m_data;
  bit         m_oob, m_ovf, m_busy, m_ack, m_prev, old_busy, old_ack;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_mode = M_IDLE;
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_ptr = 0; m_sum = 8'h00; m_data = 8'h00;
      m_oob = 0; m_ovf = 0; m_busy = 0; m_ack = 0; m_prev = 0;
    end else begin
      old_busy = m_busy;
      old_ack  = m_ack;
      m_ack    = 0;
      case (m_mode)
        M_IDLE: if (bus.ld_start) begin
          m_mode = M_LOAD; m_ptr = 0; m_sum = 8'h00;
        end
        M_LOAD: begin
          if (bus.ld_valid) begin
            if (m_ptr < DEPTH) begin
              m_mem[m_ptr] = bus.ld_data;
              m_sum = m_sum + bus.ld_data;
              m_ptr++;
            end else m_oob = 1;
          end
          if (bus.ld_done) m_mode = M_RUN;
        end
        M_RUN: begin
          if (bus.ld_start) begin
            m_mode = M_LOAD; m_ptr = 0; m_sum = 8'h00; m_busy = 0;
          end else begin
            if (m_busy && cyc == m_due) begin
              m_ack  = 1;
              m_data = (m_addr < DEPTH) ? m_mem[m_addr] : 8'h00;
              m_busy = 0;
            end
            if (bus.rd_req && !m_prev) begin
              if (old_busy || old_ack) m_ovf = 1;
              else begin
                m_busy = 1;
                m_addr = int'(bus.rd_addr);
                m_due  = cyc + RD_LAT;
                if (m_addr >= DEPTH) m_oob = 1;
              end
            end
          end
        end
        default: m_mode = M_IDLE;
      endcase
      m_prev = bus.rd_req;
    end
    #1;
    chk("ld_ready", bus.ld_ready, (m_mode == M_LOAD) && (m_ptr < DEPTH));
    chk("run",      bus.run,      m_mode == M_RUN);
    chk("rd_ack",   bus.rd_ack,   m_ack);
    chk("rd_data",  bus.rd_data,  m_data);
    chk("busy",     bus.busy,     m_busy);
    chk("err_oob",  bus.err_oob,  m_oob);
    chk("err_ovf",  bus.err_ovf,  m_ovf);
`ifdef MEM_CHECKSUM_EN
    chk("checksum", bus.checksum, m_sum);
`else
    chk("checksum", bus.checksum, 0);
`endif
  end

  logic [7:0] lq[$];

  // Caller sits at a negedge; leaves at the negedge after ld_done was sampled.
  task automatic load_q(input bit merge_done);
    bus.ld_start = 1'b1;
    @(negedge clock);
    bus.ld_start = 1'b0;
    foreach (lq[i]) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = lq[i];
      if (merge_done && i == lq.size() - 1) bus.ld_done = 1'b1;
      @(negedge clock);
    end
    bus.ld_valid = 1'b0;
    if (!merge_done) begin
      bus.ld_done = 1'b1;
      @(negedge clock);
    end
    bus.ld_done = 1'b0;
  endtask

  task automatic do_read(input int a, output logic [7:0] d, output int lat);
    bus.rd_addr = ADDR_W'(a);
    bus.rd_req  = 1'b1;
    @(negedge clock);
    bus.rd_req = 1'b0;
    lat = 0;
    while (!bus.rd_ack && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    d = bus.rd_data;
    repeat (2) @(negedge clock);
  endtask

  logic [7:0] d;
  int lat, acks;

  initial begin
    reset = 1'b1;
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_done = 1'b0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_run", bus.run, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_ld_ready", bus.ld_ready, 0);

    // 1: basic load and read
    lq = '{8'h11, 8'h22, 8'h33};
    load_q(1'b0);
    chk("t1_run", bus.run, 1);
`ifdef MEM_CHECKSUM_EN
    chk("t1_checksum", bus.checksum, 8'h66);
`else
    chk("t1_checksum", bus.checksum, 0);
`endif
    do_read(2, d, lat);
    chk("t1_latency", lat, RD_LAT);
    chk("t1_data", d, 8'h33);

    // 2: overfill a DEPTH-word memory
    bus.ld_start = 1'b1;
    @(negedge clock);
    bus.ld_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'(i + 1);
      @(negedge clock);
      if (i == 8) begin
        chk("t2_ready_low", bus.ld_ready, 0);
        chk("t2_oob_not_yet", bus.err_oob, 0);
      end
    end
    bus.ld_valid = 1'b0;
    chk("t2_oob", bus.err_oob, 1);
    bus.ld_done = 1'b1;
    @(negedge clock);
    bus.ld_done = 1'b0;
    do_read(8, d, lat);
    chk("t2_data8", d, 8'h09);
    do_read(9, d, lat);
    chk("t2_ack9", lat, RD_LAT);
    chk("t2_data9", d, 8'h00);

    // 3: level-held strobe, then a second edge while busy
    bus.rd_addr = 8'd1;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      bus.rd_req = (i < 5);
      @(negedge clock);
      if (bus.rd_ack) acks++;
    end
    chk("t3_level_acks", acks, 1);
    chk("t3_data", bus.rd_data, 8'h02);
    chk("t3_ovf_clear", bus.err_ovf, 0);
    bus.rd_addr = 8'd3;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      bus.rd_req = (i == 0 || i == 2);
      @(negedge clock);
      if (bus.rd_ack) acks++;
    end
    chk("t3_ovf_acks", acks, 1);
    chk("t3_ovf", bus.err_ovf, 1);

    // 4: reset during a read
    bus.rd_addr = 8'd0;
    bus.rd_req  = 1'b1;
    @(negedge clock);
    bus.rd_req = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus.rd_ack) acks++;
    end
    chk("t4_no_ack", acks, 0);
    chk("t4_busy", bus.busy, 0);
    chk("t4_run", bus.run, 0);
    chk("t4_idle", bus.ld_ready, 0);
    lq = '{8'hA5, 8'h5A};
    load_q(1'b0);
    do_read(0, d, lat);
    chk("t4_data0", d, 8'hA5);
    do_read(2, d, lat);
    chk("t4_cleared", d, 8'h00);

    // 5: ld_start aborts an in-flight read
    bus.rd_addr = 8'd1;
    bus.rd_req  = 1'b1;
    @(negedge clock);
    bus.rd_req   = 1'b0;
    bus.ld_start = 1'b1;
    @(negedge clock);
    bus.ld_start = 1'b0;
    chk("t5_run", bus.run, 0);
    chk("t5_busy", bus.busy, 0);
    acks = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.rd_ack) acks++;
    end
    chk("t5_no_ack", acks, 0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h7E;
    @(negedge clock);
    bus.ld_valid = 1'b0;
    bus.ld_done  = 1'b1;
    @(negedge clock);
    bus.ld_done = 1'b0;
    do_read(1, d, lat);
    chk("t5_retained", d, 8'h5A);
    do_read(0, d, lat);
    chk("t5_data0", d, 8'h7E);

    // 6: ld_done on the final handshake
    lq = '{8'h10, 8'hFF};
    load_q(1'b1);
    chk("t6_run", bus.run, 1);
`ifdef MEM_CHECKSUM_EN
    chk("t6_checksum", bus.checksum, 8'h0F);
`else
    chk("t6_checksum", bus.checksum, 0);
`endif
    do_read(1, d, lat);
    chk("t6_data1", d, 8'hFF);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      bus.ld_start = ($urandom_range(0, 59) == 0);
      bus.ld_valid = $urandom_range(0, 1) == 1;
      bus.ld_data  = 8'($urandom);
      bus.ld_done  = ($urandom_range(0, 19) == 0);
      bus.rd_req   = ($urandom_range(0, 2) == 0);
      bus.rd_addr  = 8'($urandom_range(0, 11));
      @(negedge clock);
    end
    reset = 1'b0;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
